// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int STAGES_DEF     = 3;
  localparam int LOAD_STAGE_DEF = 2;
  localparam int SB_RD_W        = 8;
  localparam int FWD_REGFILE    = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wr;
    logic               load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination scoreboard: one entry per post-decode stage, index 0 = EX.
// Shifts on advance, takes a bubble instead of the ID instruction on request, freezes otherwise.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int STAGES = STAGES_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   advance_i,
  input  logic                   insert_bubble_i,
  input  sb_entry_t              new_entry_i,
  output sb_entry_t [STAGES-1:0] entries_o
);

  sb_entry_t [STAGES-1:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (advance_i) begin
      for (int k = STAGES - 1; k > 0; k--) sb_d[k] = sb_q[k-1];
      sb_d[0] = insert_bubble_i ? '0 : new_entry_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign entries_o = sb_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller beside the ID stage.
// Defining HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt event counters.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int STAGES     = STAGES_DEF,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int FWD_W      = $clog2(STAGES + 1)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              ex_redirect,
  input  logic              ext_hold,
  output logic              if_stall,
  output logic              id_bubble,
  output logic              flush_ifid,
  output logic [FWD_W-1:0]  fwd_sel_rs1,
  output logic [FWD_W-1:0]  fwd_sel_rs2
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  sb_entry_t [STAGES-1:0] sb;
  sb_entry_t              new_entry;
  logic [FWD_W-1:0]       sel1, sel2;
  logic                   ld1, ld2;
  logic                   load_use, redirect, stall_eff;

  function automatic logic src_hit(input sb_entry_t e, input logic [REG_AW-1:0] s,
                                   input logic used, input logic idv);
    return idv && used && e.valid && e.wr && (s != '0) && (e.rd == SB_RD_W'(s));
  endfunction

  // Descending scan so the youngest (lowest index) producer is the last to win.
  always_comb begin
    sel1 = FWD_W'(FWD_REGFILE);
    sel2 = FWD_W'(FWD_REGFILE);
    ld1  = 1'b0;
    ld2  = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (src_hit(sb[k-1], id_rs1, id_rs1_used, id_valid)) begin
        sel1 = FWD_W'(k);
        ld1  = sb[k-1].load && (k < LOAD_STAGE);
      end
      if (src_hit(sb[k-1], id_rs2, id_rs2_used, id_valid)) begin
        sel2 = FWD_W'(k);
        ld2  = sb[k-1].load && (k < LOAD_STAGE);
      end
    end
  end

  assign load_use  = ld1 | ld2;
  assign redirect  = ex_redirect & ~ext_hold;
  assign stall_eff = load_use & ~ext_hold & ~ex_redirect;

  assign if_stall    = ~Reset & (ext_hold | stall_eff);
  assign id_bubble   = ~Reset & ~ext_hold & (ex_redirect | load_use);
  assign flush_ifid  = ~Reset & redirect;
  assign fwd_sel_rs1 = (Reset || ld1) ? FWD_W'(FWD_REGFILE) : sel1;
  assign fwd_sel_rs2 = (Reset || ld2) ? FWD_W'(FWD_REGFILE) : sel2;

  assign new_entry = '{valid: id_valid, rd: SB_RD_W'(id_rd), wr: id_wr, load: id_load};

  hazard_scoreboard #(.STAGES(STAGES)) u_sb (
    .clk_i          (CLK),
    .rst_i          (Reset),
    .advance_i      (~ext_hold),
    .insert_bubble_i(ex_redirect | load_use),
    .new_entry_i    (new_entry),
    .entries_o      (sb)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_eff && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect && (flush_cnt_q != '1))  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
